// File: rtl/srt_quo_rem_finalize.sv
// -----------------------------------------------------------------------------
// srt_quo_rem_finalize
//
// Back end of the radix-4 SRT divider. It takes the core's signed quotient
// digits and builds the binary quotient on the fly, so no carry-propagate
// conversion is needed at the end. It then takes the final normalized partial
// remainder, corrects a negative remainder by adding the divisor back (the
// quotient then comes from the Q-1 register), and shifts the remainder right
// to undo the core's normalization. The result is held on a valid/ready port.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a new result; latches norm_shift; honoured only in IDLE
//   norm_shift  left-normalization shift the core applied (SHW bits)
//   dig_valid   qualifies dig for one cycle; used only in ACCUM
//   dig         signed quotient digit, legal range -2..+2 (3 bits)
//   rem_valid   qualifies prem/dvs_norm for one cycle; used only in WAIT_REM
//   prem        signed final partial remainder, normalized (WIDTH+1 bits)
//   dvs_norm    normalized divisor (WIDTH bits)
//   busy        high in every state except IDLE
//   out_valid   quo/rem valid (DONE state)
//   out_ready   consumer accepts the result
//   quo         final quotient (WIDTH bits)
//   rem         final remainder (WIDTH bits)
//   err         sticky: an illegal digit was seen since the last start
// -----------------------------------------------------------------------------
module srt_quo_rem_finalize #(
   parameter int WIDTH = 64,
   parameter int NDIG  = 32,
   parameter int SHW   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [SHW-1:0]   norm_shift,
   input  logic             dig_valid,
   input  logic [2:0]       dig,
   input  logic             rem_valid,
   input  logic [WIDTH:0]   prem,
   input  logic [WIDTH-1:0] dvs_norm,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             err
);

   // Counter wide enough to hold NDIG itself, since it saturates there.
   localparam int CW = $clog2(NDIG + 1);

   localparam logic [WIDTH-1:0] K1 = WIDTH'(1);
   localparam logic [WIDTH-1:0] K3 = WIDTH'(3);
   localparam logic [WIDTH-1:0] K4 = WIDTH'(4);
   localparam logic [CW-1:0]    LAST_DIG = CW'(NDIG - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_WAIT_REM,
      S_CORRECT,
      S_DENORM,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] q;        // quotient so far
   logic [WIDTH-1:0] qm;       // quotient so far minus one
   logic [CW-1:0]    dcnt;     // accepted digits
   logic [SHW-1:0]   shcnt;    // remaining denormalization shifts
   logic [WIDTH:0]   prem_r;   // latched partial remainder
   logic [WIDTH-1:0] dvs_r;    // latched divisor
   logic [WIDTH:0]   r;        // remainder being corrected / denormalized

   // --------------------------------------------------------------------------
   // On-the-fly conversion
   //
   // Q and QM = Q-1 are both kept so that a negative digit never needs a borrow
   // to ripple through Q: appending a negative digit to Q is the same as
   // appending (4+d) to QM. Everything wraps mod 2^WIDTH.
   // --------------------------------------------------------------------------
   logic             dig_legal;
   logic             dig_zero;
   logic [WIDTH-1:0] dext;
   logic [WIDTH-1:0] q4;
   logic [WIDTH-1:0] qm4;
   logic [WIDTH-1:0] q_otf;
   logic [WIDTH-1:0] qm_otf;

   // Codes 3'b011 (+3) and 3'b100 (-4) are outside the radix-4 digit set.
   assign dig_legal = (dig != 3'b011) && (dig != 3'b100);
   // An illegal digit is folded into the zero-digit path.
   assign dig_zero  = !dig_legal || (dig == 3'b000);
   assign dext      = {{(WIDTH-3){dig[2]}}, dig};
   assign q4        = {q[WIDTH-3:0], 2'b00};
   assign qm4       = {qm[WIDTH-3:0], 2'b00};

   // NOTE: every output of a combinational block gets a default before any
   // branch; a path that leaves one unassigned would infer a latch.
   always_comb begin
      q_otf  = q4;
      qm_otf = qm4 + K3;
      if (!dig_zero) begin
         if (!dig[2]) begin
            q_otf  = q4 + dext;
            qm_otf = q4 + dext - K1;
         end else begin
            q_otf  = qm4 + K4 + dext;
            qm_otf = qm4 + K3 + dext;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Negative-remainder correction: add the divisor back (zero-extended into
   // the WIDTH+1 bit remainder, carry out of the top bit discarded).
   // --------------------------------------------------------------------------
   logic [WIDTH:0] r_fixed;
   assign r_fixed = prem_r + {1'b0, dvs_r};

   // --------------------------------------------------------------------------
   // Control and datapath
   // --------------------------------------------------------------------------
   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge value of every other register, whatever the order
   // of the statements.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         q      <= '0;
         qm     <= '0;
         dcnt   <= '0;
         shcnt  <= '0;
         prem_r <= '0;
         dvs_r  <= '0;
         r      <= '0;
         quo    <= '0;
         rem    <= '0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  q     <= '0;
                  qm    <= '1;
                  dcnt  <= '0;
                  shcnt <= norm_shift;
                  err   <= 1'b0;
                  state <= S_ACCUM;
               end
            end

            S_ACCUM: begin
               // A rem_valid arriving here is deliberately dropped; the core
               // re-presents it once we are waiting for it.
               if (dig_valid) begin
                  q  <= q_otf;
                  qm <= qm_otf;
                  if (!dig_legal) begin
                     err <= 1'b1;
                  end
                  dcnt <= dcnt + 1'b1;
                  if (dcnt == LAST_DIG) begin
                     state <= S_WAIT_REM;
                  end
               end
            end

            S_WAIT_REM: begin
               if (rem_valid) begin
                  prem_r <= prem;
                  dvs_r  <= dvs_norm;
                  state  <= S_CORRECT;
               end
            end

            S_CORRECT: begin
               if (prem_r[WIDTH]) begin
                  r   <= r_fixed;
                  quo <= qm;
               end else begin
                  r   <= prem_r;
                  quo <= q;
               end
               state <= S_DENORM;
            end

            S_DENORM: begin
               // One bit per cycle: latency follows the shift amount, which
               // is what the downstream timing budget expects.
               if (shcnt == '0) begin
                  rem   <= r[WIDTH-1:0];
                  state <= S_DONE;
               end else begin
                  r     <= r >> 1;
                  shcnt <= shcnt - 1'b1;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // Both flags are straight decodes of the state register.
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_srt_quo_rem_finalize.sv
// -----------------------------------------------------------------------------
// tb_srt_quo_rem_finalize
//
// Bench for srt_quo_rem_finalize at WIDTH=8, NDIG=4, SHW=3. Each scenario
// pushes its expected result, computed from a positional sum of the digits
// and a plain remainder correction/shift, onto a scoreboard queue; the entry
// is popped and compared when the DUT presents the result.
// -----------------------------------------------------------------------------
module tb_srt_quo_rem_finalize;

   localparam int WIDTH = 8;
   localparam int NDIG  = 4;
   localparam int SHW   = 3;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [SHW-1:0]   norm_shift;
   logic             dig_valid;
   logic [2:0]       dig;
   logic             rem_valid;
   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] dvs_norm;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             err;

   int n_vec;
   int n_bad;

   typedef struct {
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] rem;
      logic             err;
      int               lat;
   } exp_t;

   exp_t sb[$];

   srt_quo_rem_finalize #(
      .WIDTH (WIDTH),
      .NDIG  (NDIG),
      .SHW   (SHW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .norm_shift (norm_shift),
      .dig_valid  (dig_valid),
      .dig        (dig),
      .rem_valid  (rem_valid),
      .prem       (prem),
      .dvs_norm   (dvs_norm),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quo        (quo),
      .rem        (rem),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digit i of a packed 4-digit word, most significant first.
   function automatic logic [2:0] dig_at(input logic [11:0] digs, input int i);
      return digs[11 - 3*i -: 3];
   endfunction

   function automatic bit is_illegal(input logic [2:0] d);
      return (d == 3'b011) || (d == 3'b100);
   endfunction

   // Quotient as the plain positional value sum(d_i * 4^(NDIG-1-i)) mod 2^8.
   function automatic logic [WIDTH-1:0] model_quo(input logic [11:0] digs);
      int acc;
      int dv;
      acc = 0;
      for (int i = 0; i < NDIG; i++) begin
         dv = is_illegal(dig_at(digs, i)) ? 0 : int'($signed(dig_at(digs, i)));
         acc = acc * 4 + dv;
      end
      return acc[WIDTH-1:0];
   endfunction

   function automatic bit any_illegal(input logic [11:0] digs);
      bit b;
      b = 1'b0;
      for (int i = 0; i < NDIG; i++) b |= is_illegal(dig_at(digs, i));
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_vec++;
      if ({busy, out_valid, err} !== 3'b000 || quo !== '0 || rem !== '0) begin
         n_bad++;
         $display("FAIL reset_state: busy=%b out_valid=%b err=%b quo=%h rem=%h, need all 0",
                  busy, out_valid, err, quo, rem);
      end
      #4;
      rst_n = 1'b1;
      step();
   endtask

   // One complete division. Options: present rem_valid early together with
   // the last digit (must be dropped), send a stray digit in WAIT_REM (must
   // be ignored), hold out_ready low for 'hold' cycles in DONE with start
   // asserted (must be ignored).
   task automatic run_div(input string name, input logic [11:0] digs,
                          input logic [WIDTH:0] p, input logic [WIDTH-1:0] dv,
                          input int sh, input bit early_rem, input bit late_dig,
                          input int hold);
      exp_t           e;
      exp_t           got;
      logic [WIDTH:0] r;
      int             lat;

      e.quo = model_quo(digs);
      if (p[WIDTH]) e.quo = e.quo - 8'd1;
      r = p[WIDTH] ? (p + {1'b0, dv}) : p;
      r = r >> sh;
      e.rem = r[WIDTH-1:0];
      e.err = any_illegal(digs);
      e.lat = 2 + sh;
      sb.push_back(e);

      start      = 1'b1;
      norm_shift = sh[SHW-1:0];
      step();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL %s start: busy=%b err=%b, need busy=1 err=0", name, busy, err);
      end

      for (int i = 0; i < NDIG; i++) begin
         dig_valid = 1'b1;
         dig       = dig_at(digs, i);
         if (i == NDIG - 1 && early_rem) begin
            rem_valid = 1'b1;
            prem      = ~p;
            dvs_norm  = ~dv;
         end
         step();
      end
      dig_valid = 1'b0;
      rem_valid = 1'b0;

      if (late_dig) begin
         dig_valid = 1'b1;
         dig       = 3'b010;
         step();
         dig_valid = 1'b0;
      end

      rem_valid = 1'b1;
      prem      = p;
      dvs_norm  = dv;
      step();
      rem_valid = 1'b0;
      prem      = '0;
      dvs_norm  = '0;

      lat = 0;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      n_vec++;
      if (lat !== e.lat) begin
         n_bad++;
         $display("FAIL %s latency: got %0d edges, need %0d", name, lat, e.lat);
      end

      for (int k = 0; k < hold; k++) begin
         start = k[0];
         step();
         n_vec++;
         if (out_valid !== 1'b1 || quo !== e.quo || rem !== e.rem) begin
            n_bad++;
            $display("FAIL %s hold%0d: out_valid=%b quo=%h rem=%h, need 1 %h %h",
                     name, k, out_valid, quo, rem, e.quo, e.rem);
         end
      end

      if (sb.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         got = sb.pop_front();
         n_vec++;
         if (quo !== got.quo || rem !== got.rem || err !== got.err) begin
            n_bad++;
            $display("FAIL %s result: quo=%0d rem=%0d err=%b, need quo=%0d rem=%0d err=%b",
                     name, quo, rem, err, got.quo, got.rem, got.err);
         end
      end

      out_ready = 1'b1;
      start     = (hold > 0);
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || quo !== e.quo || rem !== e.rem ||
          err !== e.err) begin
         n_bad++;
         $display("FAIL %s release: out_valid=%b busy=%b quo=%h rem=%h err=%b, need 0 0 %h %h %b",
                  name, out_valid, busy, quo, rem, err, e.quo, e.rem, e.err);
      end
      step();
   endtask

   // -----------------------------------------------------------------------
   task automatic test_basic();
      // +1,-1,+2,0 -> 56; positive remainder passes through.
      run_div("basic", {3'b001, 3'b111, 3'b010, 3'b000}, 9'd5, 8'hC0, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_neg_rem();
      // Negative remainder: quotient from QM (55), rem (-3+192)>>2 = 47.
      run_div("neg_rem", {3'b001, 3'b111, 3'b010, 3'b000}, 9'h1FD, 8'hC0, 2, 1'b0, 1'b0, 0);
   endtask

   task automatic test_all_neg();
      run_div("neg2_pos", {4{3'b110}}, 9'd7, 8'h90, 1, 1'b0, 1'b0, 0);
      run_div("neg2_neg", {4{3'b110}}, 9'h1F0, 8'h90, 3, 1'b0, 1'b0, 0);
   endtask

   task automatic test_illegal_digit();
      run_div("illegal", {3'b000, 3'b100, 3'b000, 3'b000}, 9'd2, 8'h80, 0, 1'b0, 1'b0, 0);
      // err must clear on the following start (checked inside run_div).
      run_div("after_err", {3'b010, 3'b001, 3'b000, 3'b111}, 9'd9, 8'hA0, 1, 1'b0, 1'b0, 0);
   endtask

   task automatic test_ignored_inputs();
      run_div("ignored", {3'b111, 3'b010, 3'b110, 3'b001}, 9'h1F8, 8'hF0, 3, 1'b1, 1'b1, 0);
   endtask

   task automatic test_reset_mid_denorm();
      start      = 1'b1;
      norm_shift = 3'd5;
      step();
      start = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         dig_valid = 1'b1;
         dig       = (i == 1) ? 3'b100 : ((i == 3) ? 3'b001 : 3'b000);
         step();
      end
      dig_valid = 1'b0;
      rem_valid = 1'b1;
      prem      = 9'd100;
      dvs_norm  = 8'hC0;
      step();
      rem_valid = 1'b0;
      step();
      step();
      n_vec++;
      if (busy !== 1'b1 || err !== 1'b1 || quo !== 8'd1) begin
         n_bad++;
         $display("FAIL pre_reset: busy=%b err=%b quo=%h, need 1 1 01", busy, err, quo);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, out_valid, err} !== 3'b000 || quo !== '0 || rem !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: busy=%b out_valid=%b err=%b quo=%h rem=%h, need all 0",
                  busy, out_valid, err, quo, rem);
      end
      #3;
      rst_n = 1'b1;
      step();
      run_div("post_reset", {3'b001, 3'b000, 3'b010, 3'b111}, 9'd40, 8'hB0, 3, 1'b0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      run_div("hold", {3'b010, 3'b110, 3'b001, 3'b010}, 9'd33, 8'hD0, 1, 1'b0, 1'b0, 10);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 6; t++) begin
         logic [11:0]      digs;
         logic [WIDTH:0]   p;
         logic [WIDTH-1:0] dv;
         logic [2:0]       d;
         digs = '0;
         for (int i = 0; i < NDIG; i++) begin
            d    = 3'($urandom_range(0, 4)) - 3'd2;
            digs = {digs[8:0], d};
         end
         dv = 8'h80 | 8'($urandom_range(0, 127));
         p  = 9'($urandom_range(0, 511));
         run_div("b2b", digs, p, dv, $urandom_range(0, 7), 1'b0, 1'b0, 0);
      end
   endtask

   // -----------------------------------------------------------------------
   initial begin
      n_vec      = 0;
      n_bad      = 0;
      start      = 1'b0;
      norm_shift = '0;
      dig_valid  = 1'b0;
      dig        = '0;
      rem_valid  = 1'b0;
      prem       = '0;
      dvs_norm   = '0;
      out_ready  = 1'b0;

      test_reset();
      test_basic();
      test_neg_rem();
      test_all_neg();
      test_illegal_digit();
      test_ignored_inputs();
      test_reset_mid_denorm();
      test_backpressure();
      test_back_to_back();

      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
